// File: rtl/vga_spram_fetch_ctrl.sv
// VGA framebuffer fetch scheduler: credit- and burst-throttled SPRAM reads into a FWFT prefetch FIFO.
// Optional feature macro: VGA_FETCH_UNDERRUN_CNT_EN (saturating underrun counter).
module vga_spram_fetch_ctrl #(
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 9600,
  parameter int MAX_BURST   = 4
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_frame_start,
  input  logic [15:0] I_base_adr,
  input  logic        I_wb_stb,
  output logic        O_vga_req,
  output logic [15:0] O_vga_adr,
  input  logic [15:0] I_vga_dat,
  input  logic        I_pix_rd,
  output logic [15:0] O_pix_dat,
  output logic        O_pix_valid,
  output logic        O_underrun,
  output logic [7:0]  O_underrun_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [15:0] FRAME_W    = 16'(FRAME_WORDS);
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t          state;
  logic [15:0]     base_adr;
  logic [15:0]     issued;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic            inflight;
  logic [BW-1:0]   burst_cnt;
  logic            underrun;
  logic [15:0]     mem [DEPTH];

  logic [CW:0]     credit_used;
  logic            has_credit;
  logic            words_left;
  logic            forced_gap;
  logic            push;
  logic            pop;
  logic            underrun_hit;

  // Credits count both stored words and the one request whose data is still on its way back.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(inflight);
  assign has_credit  = credit_used < (CW+1)'(DEPTH);
  assign words_left  = issued < FRAME_W;
  assign forced_gap  = burst_cnt == BW'(MAX_BURST);

  assign O_vga_req   = (state == FETCH) && has_credit && words_left && !forced_gap;
  assign O_vga_adr   = base_adr + issued;
  assign O_pix_valid = fifo_count != '0;
  assign O_pix_dat   = O_pix_valid ? mem[rd_ptr] : 16'h0000;
  assign O_underrun  = underrun;

  // A frame start discards both the capture and the pop landing on the same edge.
  assign push         = inflight && !I_frame_start;
  assign pop          = I_pix_rd && O_pix_valid && !I_frame_start;
  assign underrun_hit = I_pix_rd && !O_pix_valid;

  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state      <= IDLE;
      base_adr   <= '0;
      issued     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= 1'b0;
      burst_cnt  <= '0;
      underrun   <= 1'b0;
    end else if (I_frame_start) begin
      state      <= FETCH;
      base_adr   <= I_base_adr;
      issued     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      inflight   <= 1'b0;
      burst_cnt  <= '0;
      underrun   <= 1'b0;
    end else begin
      inflight <= O_vga_req;
      if (O_vga_req) begin
        issued <= issued + 16'd1;
        if (issued == FRAME_LAST) state <= DONE;
      end
      burst_cnt <= (O_vga_req && I_wb_stb) ? burst_cnt + BW'(1) : '0;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (underrun_hit) underrun <= 1'b1;
    end
  end

  always_ff @(posedge I_clk) begin
    if (push) mem[wr_ptr] <= I_vga_dat;
  end

`ifdef VGA_FETCH_UNDERRUN_CNT_EN
  logic [7:0] underrun_cnt;
  // Survives frame starts so software can read a long-term underrun tally.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      underrun_cnt <= 8'h00;
    end else if (underrun_hit && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
  assign O_underrun_cnt = underrun_cnt;
`else
  assign O_underrun_cnt = 8'h00;
`endif

endmodule
